// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM encoding, controller cycle length
// and the counter sizing helper.
package sdram_pkg;

  // Clocks per SDRAM controller command cycle (IDLE..LAST)
  localparam int CMD_CYCLE = 6;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  // Counter holds at most max(acc_len, rec_len) - 1
  function automatic int cnt_width(input int acc_len, input int rec_len);
    int m;
    m = (acc_len > rec_len) ? acc_len : rec_len;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sdram_arb_if.sv
// Bus bundle between the two requesters / SDRAM controller (master) and the arbiter (slave).
interface sdram_arb_if;
  logic        a_req;
  logic        a_we;
  logic [24:0] a_addr;
  logic [7:0]  a_din;
  logic [7:0]  a_dout;
  logic        a_ack;

  logic        b_req;
  logic        b_we;
  logic [24:0] b_addr;
  logic [7:0]  b_din;
  logic [7:0]  b_dout;
  logic        b_ack;

  logic [24:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_oe;
  logic        ram_we;
  logic [7:0]  ram_dout;

  modport master (
    output a_req, a_we, a_addr, a_din,
    input  a_dout, a_ack,
    output b_req, b_we, b_addr, b_din,
    input  b_dout, b_ack,
    input  ram_addr, ram_din, ram_oe, ram_we,
    output ram_dout
  );

  modport slave (
    input  a_req, a_we, a_addr, a_din,
    output a_dout, a_ack,
    input  b_req, b_we, b_addr, b_din,
    output b_dout, b_ack,
    output ram_addr, ram_din, ram_oe, ram_we,
    input  ram_dout
  );
endinterface

// File: rtl/sdram_arb_port.sv
// Per-port completion logic: one-clock ack pulse and read-data holding register.
module sdram_arb_port (
  input  logic       clk,
  input  logic       init_n,
  input  logic       fire,
  input  logic       we_lat,
  input  logic [7:0] ram_dout,
  output logic [7:0] dout,
  output logic       ack
);

  // dout only moves on a completed read; writes leave the last read value visible
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      dout <= '0;
      ack  <= 1'b0;
    end else begin
      ack <= fire;
      if (fire && !we_lat) dout <= ram_dout;
    end
  end

endmodule

// File: rtl/sdram_arb.sv
// SDRAM two-port arbiter: time-slices ports A and B onto a single controller slot.
// Define SDRAM_ARB_RR_EN for round-robin on ties; otherwise port A has fixed priority.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a_req/b_req; grant and latch request on the edge
// ST_ACCESS  | ram_oe or ram_we held high for ACC_LEN clocks
// ST_RECOVER | ram_oe/ram_we low for REC_LEN clocks so the controller sees a low
module sdram_arb
  import sdram_pkg::*;
#(
  parameter int CYCLE_LEN = CMD_CYCLE,
  parameter int ACC_LEN   = 2 * CYCLE_LEN,
  parameter int REC_LEN   = CYCLE_LEN
) (
  input logic        clk,
  input logic        init_n,
  sdram_arb_if.slave bus
);

  // ACC_LEN >= 2 and REC_LEN >= 1 are assumed by the counter loads below
  localparam int              CW       = cnt_width(ACC_LEN, REC_LEN);
  localparam logic [CW-1:0] ACC_LOAD = CW'(ACC_LEN - 1);
  localparam logic [CW-1:0] REC_LOAD = CW'(REC_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  port_sel_e     gnt;
  port_sel_e     pick;
  logic          we_lat;

  logic          pick_we;
  logic [24:0]   pick_addr;
  logic [7:0]    pick_din;
  logic          any_req;

  logic [24:0]   ram_addr_q;
  logic [7:0]    ram_din_q;
  logic          ram_oe_q;
  logic          ram_we_q;

  logic          fire;
  logic          fire_a;
  logic          fire_b;
  logic [7:0]    a_dout;
  logic [7:0]    b_dout;
  logic          a_ack;
  logic          b_ack;

  assign any_req = bus.a_req | bus.b_req;

`ifdef SDRAM_ARB_RR_EN
  port_sel_e rr_next;

  always_comb begin
    pick = PORT_A;
    if (bus.a_req && bus.b_req) pick = rr_next;
    else if (bus.b_req)         pick = PORT_B;
  end

  // rr_next is the port that wins the next tie
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      rr_next <= PORT_A;
    end else if (state == ST_IDLE && any_req) begin
      rr_next <= (pick == PORT_A) ? PORT_B : PORT_A;
    end
  end
`else
  always_comb begin
    pick = PORT_A;
    if (!bus.a_req && bus.b_req) pick = PORT_B;
  end
`endif

  assign pick_we   = (pick == PORT_B) ? bus.b_we   : bus.a_we;
  assign pick_addr = (pick == PORT_B) ? bus.b_addr : bus.a_addr;
  assign pick_din  = (pick == PORT_B) ? bus.b_din  : bus.a_din;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      gnt        <= PORT_A;
      we_lat     <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_oe_q   <= 1'b0;
      ram_we_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state      <= ST_ACCESS;
            cnt        <= ACC_LOAD;
            gnt        <= pick;
            we_lat     <= pick_we;
            ram_addr_q <= pick_addr;
            ram_din_q  <= pick_din;
            ram_oe_q   <= ~pick_we;
            ram_we_q   <= pick_we;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state    <= ST_RECOVER;
            cnt      <= REC_LOAD;
            ram_oe_q <= 1'b0;
            ram_we_q <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_RECOVER: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - CNT_ONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Fires one clock early so the registered ack lands on the last ACCESS clock
  assign fire   = (state == ST_ACCESS) && (cnt == CNT_ONE);
  assign fire_a = fire && (gnt == PORT_A);
  assign fire_b = fire && (gnt == PORT_B);

  sdram_arb_port u_port_a (
    .clk      (clk),
    .init_n   (init_n),
    .fire     (fire_a),
    .we_lat   (we_lat),
    .ram_dout (bus.ram_dout),
    .dout     (a_dout),
    .ack      (a_ack)
  );

  sdram_arb_port u_port_b (
    .clk      (clk),
    .init_n   (init_n),
    .fire     (fire_b),
    .we_lat   (we_lat),
    .ram_dout (bus.ram_dout),
    .dout     (b_dout),
    .ack      (b_ack)
  );

  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;
  assign bus.ram_oe   = ram_oe_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.a_dout   = a_dout;
  assign bus.a_ack    = a_ack;
  assign bus.b_dout   = b_dout;
  assign bus.b_ack    = b_ack;

endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: transaction-timeline model, per-cycle compare, SDRAM controller model.
module tb_sdram_arb;

  localparam int ACC = 12;
  localparam int REC = 6;
  localparam int CYC = 6;
`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic init_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  sdram_arb_if bus ();

  sdram_arb dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_val(input logic [24:0] a);
    if (a == 25'h000123) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ {7'd0, a[24]} ^ 8'h3C;
  endfunction

  // SDRAM controller: samples ram_oe at each cycle start, returns data 4 clocks later
  int ctl_phase = 0;
  int rise_cnt = 0;
  initial begin
    int          cyc;
    int          rd_at;
    logic        prev_oe;
    logic [24:0] rd_addr;
    cyc = 0; rd_at = -1; prev_oe = 1'b0; rd_addr = '0;
    bus.ram_dout = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_at == cyc) bus.ram_dout = mem_val(rd_addr);
      if (cyc % CYC == ctl_phase) begin
        if (bus.ram_oe && !prev_oe) begin
          rise_cnt++;
          rd_addr = bus.ram_addr;
          rd_at = cyc + 4;
          bus.ram_dout = 8'hEE;
        end
        prev_oe = bus.ram_oe;
      end
    end
  end

  // Timeline model: a grant at clock 0 owns the bus for clocks 1..ACC, idles again at ACC+REC+1
  logic        e_oe, e_we, e_a_ack, e_b_ack;
  logic [7:0]  e_a_dout, e_b_dout, e_din;
  logic [24:0] e_addr;
  initial begin
    bit          m_busy, m_port, m_we, m_next;
    int          m_k;
    logic [24:0] m_addr;
    logic [7:0]  m_din;
    m_busy = 0; m_port = 0; m_we = 0; m_next = 0; m_k = 0; m_addr = '0; m_din = '0;
    e_oe = 0; e_we = 0; e_a_ack = 0; e_b_ack = 0; e_a_dout = '0; e_b_dout = '0;
    e_din = '0; e_addr = '0;
    forever begin
      @(posedge clk or negedge init_n);
      if (!init_n) begin
        m_busy = 0; m_port = 0; m_we = 0; m_next = 0; m_k = 0; m_addr = '0; m_din = '0;
        e_oe = 0; e_we = 0; e_a_ack = 0; e_b_ack = 0; e_a_dout = '0; e_b_dout = '0;
        e_din = '0; e_addr = '0;
      end else begin
        e_a_ack = 0; e_b_ack = 0;
        if (!m_busy) begin
          if (bus.a_req || bus.b_req) begin
            if (bus.a_req && bus.b_req) m_port = m_next;
            else                        m_port = !bus.a_req;
`ifdef SDRAM_ARB_RR_EN
            m_next = !m_port;
`endif
            m_we   = m_port ? bus.b_we   : bus.a_we;
            m_addr = m_port ? bus.b_addr : bus.a_addr;
            m_din  = m_port ? bus.b_din  : bus.a_din;
            m_busy = 1; m_k = 1;
          end
        end else begin
          m_k++;
          if (m_k > ACC + REC) m_busy = 0;
        end
        e_oe = m_busy && (m_k <= ACC) && !m_we;
        e_we = m_busy && (m_k <= ACC) && m_we;
        e_addr = m_addr;
        e_din = m_din;
        if (m_busy && m_k == ACC) begin
          if (m_port) begin
            e_b_ack = 1;
            if (!m_we) e_b_dout = mem_val(m_addr);
          end else begin
            e_a_ack = 1;
            if (!m_we) e_a_dout = mem_val(m_addr);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && init_n) begin
        check("ram_oe", bus.ram_oe, e_oe);
        check("ram_we", bus.ram_we, e_we);
        check("a_ack", bus.a_ack, e_a_ack);
        check("b_ack", bus.b_ack, e_b_ack);
        check("a_dout", bus.a_dout, e_a_dout);
        check("b_dout", bus.b_dout, e_b_dout);
        check("ram_addr", bus.ram_addr, e_addr);
        check("ram_din", bus.ram_din, e_din);
        check("oe_we_excl", bus.ram_oe & bus.ram_we, 1'b0);
      end
    end
  end

  task automatic wait_ack(input bit port, input int lim, output int n, output int oe_c, output int we_c);
    bit got;
    got = 0; n = 0; oe_c = 0; we_c = 0;
    while (!got && n < lim) begin
      @(negedge clk);
      n++;
      if (bus.ram_oe) oe_c++;
      if (bus.ram_we) we_c++;
      got = port ? bus.b_ack : bus.a_ack;
    end
    check(port ? "b_ack_seen" : "a_ack_seen", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, oe_c, we_c, t, na, rise_prev;
    int who[3];
    int at[3];
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_din = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_din = '0;
    init_n = 0;
    repeat (3) @(negedge clk);
    check("rst_oe", bus.ram_oe, 0);
    check("rst_we", bus.ram_we, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_a_dout", bus.a_dout, 0);
    check("rst_b_ack", bus.b_ack, 0);
    init_n = 1;
    chk_en = 1;
    repeat (2) @(negedge clk);

    // A read alone
    bus.a_we = 0; bus.a_addr = 25'h000123; bus.a_din = 8'h11; bus.a_req = 1;
    wait_ack(0, 40, n, oe_c, we_c);
    bus.a_req = 0;
    check("a_rd_ack_lat", n, 12);
    check("a_rd_oe_clks", oe_c, 12);
    check("a_rd_dout", bus.a_dout, 8'h5A);
    check("a_rd_addr", bus.ram_addr, 25'h000123);
    repeat (10) @(negedge clk);

    // B write at top address
    bus.b_we = 1; bus.b_addr = 25'h1FFFFFF; bus.b_din = 8'hC3; bus.b_req = 1;
    wait_ack(1, 40, n, oe_c, we_c);
    bus.b_req = 0;
    check("b_wr_ack_lat", n, 12);
    check("b_wr_we_clks", we_c, 12);
    check("b_wr_oe_clks", oe_c, 0);
    check("b_wr_din", bus.ram_din, 8'hC3);
    check("b_wr_dout_kept", bus.b_dout, 8'h00);
    check("b_wr_a_dout_kept", bus.a_dout, 8'h5A);
    repeat (10) @(negedge clk);

    // Simultaneous held requests
    bus.a_we = 0; bus.a_addr = 25'h0000200;
    bus.b_we = 0; bus.b_addr = 25'h0000456;
    bus.a_req = 1; bus.b_req = 1;
    t = 0; na = 0;
    while (na < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (bus.a_ack) begin who[na] = 0; at[na] = t; na++; end
      else if (bus.b_ack) begin who[na] = 1; at[na] = t; na++; end
    end
    bus.a_req = 0; bus.b_req = 0;
    check("arb_ack_count", na, 3);
    if (na == 3) begin
      check("arb_first_port", who[0], 0);
      check("arb_second_port", who[1], RR ? 1 : 0);
      check("arb_third_port", who[2], 0);
      check("arb_first_lat", at[0], 12);
      check("arb_gap1", at[1] - at[0], 19);
      check("arb_gap2", at[2] - at[1], 19);
    end
    repeat (10) @(negedge clk);

    // Request dropped before ack still completes
    bus.b_we = 0; bus.b_addr = 25'h0000777; bus.b_req = 1;
    repeat (3) @(negedge clk);
    bus.b_req = 0;
    wait_ack(1, 40, n, oe_c, we_c);
    check("b_drop_ack_lat", n, 9);
    check("b_drop_dout", bus.b_dout, 8'h4C);
    repeat (10) @(negedge clk);

    // Reset in the middle of an access
    bus.a_we = 0; bus.a_addr = 25'h00001F0; bus.a_req = 1;
    repeat (5) @(negedge clk);
    check("mid_rst_oe_before", bus.ram_oe, 1);
    #2 init_n = 0;
    #1;
    check("mid_rst_oe_after", bus.ram_oe, 0);
    check("mid_rst_ack", bus.a_ack, 0);
    check("mid_rst_dout", bus.a_dout, 0);
    @(negedge clk);
    init_n = 1;
    wait_ack(0, 40, n, oe_c, we_c);
    bus.a_req = 0;
    check("post_rst_ack_lat", n, 12);
    check("post_rst_dout", bus.a_dout, 8'hCD);
    repeat (10) @(negedge clk);

    // Back-to-back reads against several controller phases
    foreach (who[j]) who[j] = 0;
    for (int p = 0; p < CYC; p += 2) begin
      ctl_phase = p + (p == 4 ? 1 : 0);
      repeat (2) @(negedge clk);
      rise_prev = rise_cnt;
      bus.a_we = 0; bus.a_addr = 25'h0100000 + 25'(p * 16); bus.a_req = 1;
      for (int i = 0; i < 3; i++) begin
        wait_ack(0, 60, n, oe_c, we_c);
        check("b2b_lat", n, (i == 0) ? 12 : 19);
        check("b2b_oe_rise", rise_cnt - rise_prev, 1);
        rise_prev = rise_cnt;
        bus.a_addr = bus.a_addr + 25'd3;
      end
      bus.a_req = 0;
      repeat (10) @(negedge clk);
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
